// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: round-robin arbiter of NUM_PORTS request channels onto one Wishbone classic master.
// Optional bus timeout with error response when BUS_TIMEOUT_EN is defined.
module core_wb_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_core,
  input  logic                             rst_core,
  input  logic [NUM_PORTS-1:0]             req_valid_i,
  output logic [NUM_PORTS-1:0]             req_ready_o,
  input  logic [NUM_PORTS-1:0]             req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic [NUM_PORTS-1:0]             rsp_valid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata_o,
  output logic [NUM_PORTS-1:0]             rsp_err_o,
  output logic                             wb_cyc_o,
  output logic                             wb_stb_o,
  output logic                             wb_we_o,
  output logic [DATA_WIDTH/8-1:0]          wb_sel_o,
  output logic [ADDR_WIDTH-1:0]            wb_addr_o,
  output logic [DATA_WIDTH-1:0]            wb_data_o,
  input  logic [DATA_WIDTH-1:0]            wb_data_i,
  input  logic                             wb_ack_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDXW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 1 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("core_wb_arbiter: unsupported parameter set");
  end

  typedef enum logic {IDLE, BUS} state_t;

  state_t                        state_q, state_d;
  logic [IDXW-1:0]               last_q, grant_q, gnt;
  logic                          found, take, done, fail;
  logic                          we_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [DATA_WIDTH-1:0]         wdata_q;
  logic [SEL_W-1:0]              sel_q;
  logic [NUM_PORTS-1:0]          rsp_valid_q, rsp_err_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;
  int                            idx;

  // search starts one past the last winner and wraps
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last_q) + k) % NUM_PORTS;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gnt   = IDXW'(idx);
      end
    end
  end

  assign take        = (state_q == IDLE) && found;
  assign done        = (state_q == BUS) && wb_ack_i;
  assign req_ready_o = take ? (NUM_PORTS'(1) << gnt) : '0;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  assign fail = (state_q == BUS) && !wb_ack_i &&
                (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= '0;
    end else if (state_q == BUS && !wb_ack_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign fail = 1'b0;
`endif

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (found)        state_d = BUS;
      BUS:  if (done || fail) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      last_q  <= IDXW'(NUM_PORTS - 1);
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
    end else if (take) begin
      last_q  <= gnt;
      grant_q <= gnt;
      we_q    <= req_we_i[gnt];
      addr_q  <= req_addr_i[gnt*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_q <= req_wdata_i[gnt*DATA_WIDTH +: DATA_WIDTH];
      sel_q   <= req_we_i[gnt] ? req_wstrb_i[gnt*SEL_W +: SEL_W] : '1;
    end
  end

  // rdata slots persist; only the responding port's slot changes
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      if (done) begin
        rsp_valid_q[grant_q] <= 1'b1;
        rdata_q[grant_q*DATA_WIDTH +: DATA_WIDTH] <= we_q ? '0 : wb_data_i;
      end else if (fail) begin
        rsp_valid_q[grant_q] <= 1'b1;
        rsp_err_q[grant_q]   <= 1'b1;
        rdata_q[grant_q*DATA_WIDTH +: DATA_WIDTH] <= '1;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rdata_q;
  assign wb_cyc_o    = (state_q == BUS);
  assign wb_stb_o    = (state_q == BUS);
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb_core_wb_arbiter: table vectors, directed corner sequences and random traffic
// against a transaction-level round-robin model (timeout path under BUS_TIMEOUT_EN).
module tb_core_wb_arbiter;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic [1:0]  req_valid_i, req_ready_o, req_we_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic [7:0]  req_wstrb_i;
  logic [1:0]  rsp_valid_o, rsp_err_o;
  logic [63:0] rsp_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;

  core_wb_arbiter #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic [1:0]  v;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          k;
    logic [31:0] sdata;
    int          eg;
    logic [3:0]  esel;
    logic [31:0] erd;
  } vec_t;

  vec_t        vecs[13];
  int          checks = 0;
  int          errors = 0;
  int          last_g;
  logic [31:0] slot[2];
  logic        pend;
  int          pend_port;
  logic        pend_err;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int p);
    logic [1:0] r;
    r = '0;
    if (p >= 0) r[p] = 1'b1;
    return r;
  endfunction

  // round robin: first valid port after the previous winner
  function automatic int model_grant(input logic [1:0] v);
    for (int off = 1; off <= 2; off++)
      if (v[(last_g + off) % 2]) return (last_g + off) % 2;
    return -1;
  endfunction

  function automatic vec_t mk(input logic [1:0] v, input logic we,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] wstrb, input int k, input logic [31:0] sdata,
    input int eg, input logic [3:0] esel, input logic [31:0] erd);
    vec_t r;
    r.v = v; r.we = we; r.addr = addr; r.wdata = wdata;
    r.wstrb = wstrb; r.k = k; r.sdata = sdata; r.eg = eg;
    r.esel = esel; r.erd = erd;
    return r;
  endfunction

  // port p sees addr+4p; port 0 data is scrambled to tell the ports apart
  task automatic drive(input logic [1:0] v, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    req_valid_i = v;
    req_we_i    = {we, we};
    req_addr_i  = {addr + 32'd4, addr};
    req_wdata_i = {wdata, wdata ^ 32'h0F0F_0F0F};
    req_wstrb_i = {wstrb, wstrb};
  endtask

  task automatic check_rsp();
    chk("rsp_valid", {62'd0, rsp_valid_o}, {62'd0, pend ? onehot(pend_port) : 2'b00});
    chk("rsp_err", {62'd0, rsp_err_o},
        {62'd0, (pend && pend_err) ? onehot(pend_port) : 2'b00});
    chk("rsp_rdata", rsp_rdata_o, {slot[1], slot[0]});
    pend = 1'b0;
  endtask

  // called at a negedge with requests already driven
  task automatic bus_txn(input int eg, input int k, input logic [31:0] sdata,
                         input logic we, input logic [3:0] esel,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erd);
    #1;
    check_rsp();
    chk("ready", {62'd0, req_ready_o}, {62'd0, onehot(eg)});
    if (eg < 0) begin
      @(negedge clk_core);
      return;
    end
    last_g = eg;
    @(negedge clk_core);
    for (int c = 1; c <= k; c++) begin
      #1;
      if (c == 1) check_rsp();
      chk("cyc", {63'd0, wb_cyc_o}, 64'd1);
      chk("stb", {63'd0, wb_stb_o}, 64'd1);
      chk("ready_bus", {62'd0, req_ready_o}, 64'd0);
      if (c == 1 || c == k) begin
        chk("we", {63'd0, wb_we_o}, {63'd0, we});
        chk("sel", {60'd0, wb_sel_o}, {60'd0, esel});
        chk("addr", {32'd0, wb_addr_o}, {32'd0, addr + 32'(eg * 4)});
        chk("wdata", {32'd0, wb_data_o},
            {32'd0, (eg == 1) ? wdata : (wdata ^ 32'h0F0F_0F0F)});
      end
      if (c == k) begin
        wb_ack_i  = 1'b1;
        wb_data_i = sdata;
      end
      @(negedge clk_core);
      wb_ack_i  = 1'b0;
      wb_data_i = $urandom;
    end
    slot[eg]  = erd;
    pend      = 1'b1;
    pend_port = eg;
    pend_err  = 1'b0;
  endtask

  task automatic reset_model();
    last_g  = 1;
    slot[0] = '0;
    slot[1] = '0;
    pend    = 1'b0;
  endtask

  initial begin
    vec_t cur;
    logic [1:0]  rv;
    logic        rwe;
    logic [31:0] ra, rwd, rsd;
    logic [3:0]  rst4;
    int          rk, reg_g, ncyc;

    vecs[0]  = mk(2'b01, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 3,
                  32'h1234_5678, 0, 4'hF, 32'h1234_5678);
    vecs[1]  = mk(2'b10, 1'b1, 32'h2000_0000, 32'hCAFE_BABE, 4'h3, 2,
                  32'hDEAD_BEEF, 1, 4'h3, 32'h0);
    for (int i = 0; i < 8; i++)
      vecs[2+i] = mk(2'b11, 1'b0, 32'h3000_0000 + 32'(i * 16), 32'h0,
                     4'h5, 1, 32'h5500_0000 + 32'(i), i % 2, 4'hF,
                     32'h5500_0000 + 32'(i));
    vecs[10] = mk(2'b00, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h0, -1, 4'h0, 32'h0);
    vecs[11] = mk(2'b01, 1'b1, 32'h4000_0010, 32'h1357_9BDF, 4'hC, 4,
                  32'h7777_7777, 0, 4'hC, 32'h0);
    vecs[12] = mk(2'b11, 1'b0, 32'h5000_0000, 32'h0, 4'h0, 8,
                  32'hA5A5_A5A5, 1, 4'hF, 32'hA5A5_A5A5);

    drive(2'b00, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_ack_i  = 1'b0;
    wb_data_i = '0;
    rst_core  = 1'b0;
    reset_model();
    #1 rst_core = 1'b1;
    #1;
    chk("rst_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    chk("rst_ready", {62'd0, req_ready_o}, 64'd0);
    chk("rst_rsp", {60'd0, rsp_valid_o, rsp_err_o}, 64'd0);
    chk("rst_rdata", rsp_rdata_o, 64'd0);
    chk("rst_wb", {wb_addr_o, wb_data_o}, 64'd0);
    chk("rst_sel_we", {59'd0, wb_sel_o, wb_we_o}, 64'd0);
    @(negedge clk_core);
    @(negedge clk_core);
    rst_core = 1'b0;

    for (int i = 0; i < 13; i++) begin
      cur = vecs[i];
      drive(cur.v, cur.we, cur.addr, cur.wdata, cur.wstrb);
      bus_txn(cur.eg, cur.k, cur.sdata, cur.we, cur.esel,
              cur.addr, cur.wdata, cur.erd);
    end

    // ack while idle must not produce a response
    drive(2'b00, 1'b0, 32'h0, 32'h0, 4'h0);
    bus_txn(-1, 1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    wb_ack_i = 1'b1;
    @(negedge clk_core);
    wb_ack_i = 1'b0;
    #1 check_rsp();
    chk("idle_ack_cyc", {63'd0, wb_cyc_o}, 64'd0);
    @(negedge clk_core);

`ifdef BUS_TIMEOUT_EN
    drive(2'b01, 1'b0, 32'h6000_0000, 32'h0, 4'h0);
    #1 chk("to_ready", {62'd0, req_ready_o}, 64'd1);
    last_g = 0;
    @(negedge clk_core);
    req_valid_i = 2'b00;
    ncyc = 0;
    while (wb_cyc_o && ncyc < 20) begin
      ncyc++;
      @(negedge clk_core);
    end
    chk("to_cyc_cycles", 64'(ncyc), 64'd8);
    slot[0]   = 32'hFFFF_FFFF;
    pend      = 1'b1;
    pend_port = 0;
    pend_err  = 1'b1;
    #1 check_rsp();
    @(negedge clk_core);
`else
    drive(2'b01, 1'b0, 32'h6000_0000, 32'h0, 4'h0);
    bus_txn(model_grant(2'b01), 1000, 32'h0BAD_F00D, 1'b0, 4'hF,
            32'h6000_0000, 32'h0, 32'h0BAD_F00D);
    drive(2'b00, 1'b0, 32'h0, 32'h0, 4'h0);
    bus_txn(-1, 1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
`endif

    // reset in the middle of a bus cycle
    drive(2'b01, 1'b0, 32'h7000_0000, 32'h0, 4'h0);
    #1 chk("mr_ready", {62'd0, req_ready_o}, {62'd0, onehot(model_grant(2'b01))});
    @(negedge clk_core);
    req_valid_i = 2'b00;
    @(negedge clk_core);
    #2 rst_core = 1'b1;
    #1 chk("mr_cyc_drop", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    @(negedge clk_core);
    rst_core = 1'b0;
    reset_model();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_core);
      #1 check_rsp();
    end
    drive(2'b11, 1'b0, 32'h7100_0000, 32'h0, 4'h0);
    bus_txn(0, 2, 32'h0101_0101, 1'b0, 4'hF, 32'h7100_0000, 32'h0,
            32'h0101_0101);

    for (int i = 0; i < 60; i++) begin
      rv   = 2'($urandom_range(0, 3));
      rwe  = 1'($urandom);
      ra   = $urandom & 32'hFFFF_FFF0;
      rwd  = $urandom;
      rst4 = 4'($urandom);
      rk   = $urandom_range(1, 5);
      rsd  = $urandom;
      reg_g = model_grant(rv);
      drive(rv, rwe, ra, rwd, rst4);
      bus_txn(reg_g, rk, rsd, rwe, rwe ? rst4 : 4'hF, ra, rwd,
              rwe ? 32'h0 : rsd);
    end
    drive(2'b00, 1'b0, 32'h0, 32'h0, 4'h0);
    bus_txn(-1, 1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter.md
Name: core_wb_arbiter

Overview:
Parametrised successor to the fixed instruction/data bus hookup of a core top. Arbitrates NUM_PORTS core-side request channels (e.g. instruction fetch, data LSU, debug) onto one Wishbone classic master port. Arbitration is round-robin. Responses are registered per port, and an optional bus timeout reports errors. Sits between a core and the Controller's core_* bus inside processorci_top.

Parameters:
NUM_PORTS, 2, number of requesting channels (1..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8); SEL_W = DATA_WIDTH/8
TIMEOUT_CYCLES, 255, bus cycles waited for wb_ack_i before error (only with BUS_TIMEOUT_EN; >=1)

Ports:
clk_core  in  1  clock, all logic on rising edge
rst_core  in  1  asynchronous, active-high reset
req_valid_i  in  NUM_PORTS  per-port request valid
req_ready_o  out  NUM_PORTS  per-port request accepted (valid&ready = handshake)
req_we_i  in  NUM_PORTS  per-port write enable
req_addr_i  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata_i  in  NUM_PORTS*DATA_WIDTH  packed write data
req_wstrb_i  in  NUM_PORTS*SEL_W  packed byte strobes
rsp_valid_o  out  NUM_PORTS  one-cycle response pulse per port
rsp_rdata_o  out  NUM_PORTS*DATA_WIDTH  packed registered read data
rsp_err_o  out  NUM_PORTS  error flag, qualified by rsp_valid_o
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe (equal to wb_cyc_o)
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  SEL_W  byte select
wb_addr_o  out  ADDR_WIDTH  address
wb_data_o  out  DATA_WIDTH  write data
wb_data_i  in  DATA_WIDTH  read data
wb_ack_i  in  1  acknowledge

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NUM_PORTS-1, so port 0 has first priority; timeout counter 0.
- FSM has two states, IDLE and BUS.
- IDLE:
  - If any req_valid_i is set, grant the first valid port searching from last_grant+1 mod NUM_PORTS upward, with wrap.
  - req_ready_o[grant] is asserted combinationally in the same cycle; all other ready bits stay 0.
  - Latch we/addr/wdata/wstrb and the grant index; update last_grant; go to BUS.
  - With no valid requests, all ready bits are 0.
- Requester rule: hold valid and payload stable until ready is seen. Arbiter may assume this and does not check it.
- BUS:
  - wb_cyc_o = wb_stb_o = 1; wb_we_o/wb_sel_o/wb_addr_o/wb_data_o driven from latched registers, stable for the whole cycle.
  - Reads drive wb_sel_o = all ones, with wstrb ignored.
  - On wb_ack_i: capture wb_data_i into the granted port's rsp_rdata slot (writes capture 0).
  - Next cycle: rsp_valid_o[grant] = 1 for exactly one cycle, rsp_err_o[grant] = 0; FSM returns to IDLE in that same edge.
- Latency: handshake at cycle T; wb_cyc_o high from T+1; ack at T+k (k>=1); rsp_valid at T+k+1. A new grant is possible in cycle T+k+1, so the response pulse and the next handshake overlap.
- rsp_rdata slots hold their value until the next response on that port.
- wb_ack_i in IDLE is ignored.
- Asynchronous reset in BUS: wb_cyc_o/wb_stb_o drop immediately; the transaction is abandoned; no response is ever produced for it.
- NUM_PORTS=1 degenerates to a registered pass-through, with grant always 0.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - Counter clears on entry to BUS and increments every BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack that cycle, cyc/stb drop at the next edge and the FSM goes to IDLE.
  - Next cycle: rsp_valid_o[grant] = 1, rsp_err_o[grant] = 1, and the rdata slot is set to all ones.
  - Maximum cyc high time is TIMEOUT_CYCLES cycles.
  - An ack arriving in the final cycle wins: normal response, err = 0.
- Undefined: no counter; BUS waits indefinitely; rsp_err_o tied 0.

Test Plan:
1. Port0 read addr 0x0000_0100; slave acks 3 cycles after cyc rises with 0x1234_5678 -> wb_sel_o=0xF, wb_we_o=0, cyc high 3 cycles; rsp_valid_o=2'b01 for one cycle; port0 rdata=0x1234_5678; err=0.
2. Both ports valid continuously after reset, slave acks in 1 cycle -> grants alternate 0,1,0,1; each port's ready seen exactly once per its turn; no starvation across 8 transactions.
3. Port1 write addr 0x2000_0004, wdata 0xCAFE_BABE, wstrb 0x3 -> wb_we_o=1, wb_sel_o=0x3, wb_data_o=0xCAFE_BABE; after ack, rsp_valid_o=2'b10; port1 rdata=0.
4. BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> cyc high exactly 8 cycles; then rsp_valid_o[0]=1, rsp_err_o[0]=1, rdata=0xFFFF_FFFF. Without the macro, cyc is still high after 1000 cycles.
5. rst_core asserted 2 cycles into a BUS transaction -> cyc/stb low before the next edge; after release, no rsp_valid; both ports valid -> port0 granted first.
6. BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack in the 4th cycle with 0xA5A5_A5A5 -> rsp_err_o=0, rdata=0xA5A5_A5A5.
